// File: rtl/emissor_codigo.sv
// emissor_codigo: plays a stored 6-digit code onto the keypad bus of the code lock.
// Each digit is presented for one EMITE cycle (insere strobe) followed by GAP idle
// cycles; a one-cycle fim pulse closes the sequence.
// Optional feature macro: EMISSOR_ERRO_INJ_EN adds erro_en/erro_idx to corrupt
// (bitwise invert) one chosen digit of a run.
module emissor_codigo #(
    parameter logic [3:0] D0  = 4'd5,
    parameter logic [3:0] D1  = 4'd9,
    parameter logic [3:0] D2  = 4'd0,
    parameter logic [3:0] D3  = 4'd9,
    parameter logic [3:0] D4  = 4'd8,
    parameter logic [3:0] D5  = 4'd1,
    parameter int         GAP = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
`ifdef EMISSOR_ERRO_INJ_EN
    input  logic       erro_en,
    input  logic [2:0] erro_idx,
`endif
    output logic [4:1] numero,
    output logic       insere,
    output logic       ocupado,
    output logic [2:0] indice,
    output logic       fim
);

    // Handshake: insere is a one-cycle valid for numero; there is no ready,
    // the lock side must accept every strobed digit.

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EMITE  = 2'd1,
        ESPERA = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam logic [3:0] GAP_M1 = 4'(GAP - 1);
    localparam logic [2:0] ULTIMO = 3'd5;

    estado_t    estado_q, estado_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] numero_q, numero_d;
    logic [2:0] indice_q, indice_d;
    logic       insere_q, insere_d;
    logic       ocupado_q, ocupado_d;
    logic       fim_q, fim_d;

    // Corruption controls as seen by the digit selector for the current cycle.
    logic       err_en_cur;
    logic [2:0] err_idx_cur;

`ifdef EMISSOR_ERRO_INJ_EN
    logic       erro_en_q, erro_en_d;
    logic [2:0] erro_idx_q, erro_idx_d;

    // In OCIOSO the start edge also captures the controls, so the first digit
    // must already see the incoming values rather than the stale registers.
    always_comb begin
        err_en_cur  = erro_en_q;
        err_idx_cur = erro_idx_q;
        if (estado_q == OCIOSO) begin
            err_en_cur  = erro_en;
            err_idx_cur = erro_idx;
        end
    end

    // Capture corruption controls only on an accepted start request.
    always_comb begin
        erro_en_d  = erro_en_q;
        erro_idx_d = erro_idx_q;
        if (estado_q == OCIOSO && iniciar) begin
            erro_en_d  = erro_en;
            erro_idx_d = erro_idx;
        end
    end

    // Corruption control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erro_en_q  <= 1'b0;
            erro_idx_q <= 3'd0;
        end else begin
            erro_en_q  <= erro_en_d;
            erro_idx_q <= erro_idx_d;
        end
    end
`else
    assign err_en_cur  = 1'b0;
    assign err_idx_cur = 3'd0;
`endif

    // Code digit for index i, optionally inverted when it is the targeted one.
    function automatic logic [3:0] digito(input logic [2:0] i, input logic en,
                                          input logic [2:0] ei);
        logic [3:0] d;
        case (i)
            3'd0:    d = D0;
            3'd1:    d = D1;
            3'd2:    d = D2;
            3'd3:    d = D3;
            3'd4:    d = D4;
            default: d = D5;
        endcase
        if (en && (i == ei)) d = ~d;
        return d;
    endfunction

    // Next-state logic; outputs are computed from the next state so that they
    // come straight out of flops with no input-to-output path.
    always_comb begin
        estado_d = estado_q;
        gap_d    = gap_q;
        numero_d = numero_q;
        indice_d = indice_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar && !abortar) begin
                    estado_d = EMITE;
                    indice_d = 3'd0;
                    numero_d = digito(3'd0, err_en_cur, err_idx_cur);
                end
            end
            EMITE: begin
                estado_d = ESPERA;
                gap_d    = GAP_M1;
            end
            ESPERA: begin
                if (gap_q == 4'd0) begin
                    if (indice_q < ULTIMO) begin
                        estado_d = EMITE;
                        indice_d = indice_q + 3'd1;
                        numero_d = digito(indice_q + 3'd1, err_en_cur, err_idx_cur);
                    end else begin
                        estado_d = FIM;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Abort overrides every other transition; numero keeps its last value.
        if (abortar && (estado_q != OCIOSO)) begin
            estado_d = OCIOSO;
            indice_d = 3'd0;
            gap_d    = 4'd0;
            numero_d = numero_q;
        end

        insere_d  = (estado_d == EMITE);
        fim_d     = (estado_d == FIM);
        ocupado_d = (estado_d != OCIOSO);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            gap_q     <= 4'd0;
            numero_q  <= 4'd0;
            indice_q  <= 3'd0;
            insere_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            gap_q     <= gap_d;
            numero_q  <= numero_d;
            indice_q  <= indice_d;
            insere_q  <= insere_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
        end
    end

    assign numero  = numero_q;
    assign insere  = insere_q;
    assign ocupado = ocupado_q;
    assign indice  = indice_q;
    assign fim     = fim_q;

endmodule

// File: tb/tb_emissor_codigo.sv
// Bench for emissor_codigo: two instances (GAP=3 and GAP=1) share one stimulus
// stream; a timeline model derived from start/abort events predicts every output.
module tb_emissor_codigo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0;
    logic       abortar = 1'b0;
    logic       erro_en = 1'b0;
    logic [2:0] erro_idx = 3'd0;

    logic [4:1] num_a, num_b;
    logic       ins_a, ins_b, ocu_a, ocu_b, fim_a, fim_b;
    logic [2:0] idx_a, idx_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    emissor_codigo #(.GAP(3)) dut_a (
        .clk(clk), .reset(rst), .iniciar(iniciar), .abortar(abortar),
`ifdef EMISSOR_ERRO_INJ_EN
        .erro_en(erro_en), .erro_idx(erro_idx),
`endif
        .numero(num_a), .insere(ins_a), .ocupado(ocu_a), .indice(idx_a), .fim(fim_a)
    );

    emissor_codigo #(.GAP(1)) dut_b (
        .clk(clk), .reset(rst), .iniciar(iniciar), .abortar(abortar),
`ifdef EMISSOR_ERRO_INJ_EN
        .erro_en(erro_en), .erro_idx(erro_idx),
`endif
        .numero(num_b), .insere(ins_b), .ocupado(ocu_b), .indice(idx_b), .fim(fim_b)
    );

    // ---------------- reference model ----------------
    logic [3:0] code_tab [0:5] = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};
    int         m_gap [0:1] = '{3, 1};
    int         cyc = 0;
    bit         m_act [0:1];
    int         m_s   [0:1];
    logic [3:0] m_num [0:1];
    logic [2:0] m_idx [0:1];
    logic       m_ins [0:1];
    logic       m_fim [0:1];
    logic       m_een [0:1];
    logic [2:0] m_eidx[0:1];

    task automatic model_reset(input int d);
        m_act[d] = 0; m_s[d] = 0; m_num[d] = 4'd0; m_idx[d] = 3'd0;
        m_ins[d] = 1'b0; m_fim[d] = 1'b0; m_een[d] = 1'b0; m_eidx[d] = 3'd0;
    endtask

    // One clock edge with the currently applied inputs. Offset o counts cycles
    // since the accepted start edge: slot i spans o = i*(G+1) .. i*(G+1)+G,
    // its strobe at the first cycle; o = 6*(G+1) is the fim cycle.
    task automatic model_edge(input int d);
        int o, g, last, i;
        bit was_busy;
        logic [3:0] v;
        g = m_gap[d];
        last = 6 * (g + 1);
        m_ins[d] = 1'b0;
        m_fim[d] = 1'b0;
        if (rst) begin
            model_reset(d);
            return;
        end
        was_busy = m_act[d];
        if (was_busy) begin
            if (abortar) begin
                m_act[d] = 0;
                m_idx[d] = 3'd0;
            end else if (cyc - m_s[d] > last) begin
                m_act[d] = 0;
            end
        end else if (iniciar && !abortar) begin
            m_act[d] = 1;
            m_s[d] = cyc;
`ifdef EMISSOR_ERRO_INJ_EN
            m_een[d] = erro_en;
            m_eidx[d] = erro_idx;
`else
            m_een[d] = 1'b0;
            m_eidx[d] = 3'd0;
`endif
        end
        if (m_act[d]) begin
            o = cyc - m_s[d];
            if (o < last) begin
                i = o / (g + 1);
                m_idx[d] = 3'(i);
                if (o % (g + 1) == 0) begin
                    m_ins[d] = 1'b1;
                    v = code_tab[i];
                    if (m_een[d] && (m_eidx[d] == 3'(i))) v = ~v;
                    m_num[d] = v;
                end
            end else begin
                m_fim[d] = 1'b1;
                m_idx[d] = 3'd5;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("a.numero",  8'(num_a), 8'(m_num[0]));
        chk("a.insere",  8'(ins_a), 8'(m_ins[0]));
        chk("a.ocupado", 8'(ocu_a), 8'(m_act[0]));
        chk("a.indice",  8'(idx_a), 8'(m_idx[0]));
        chk("a.fim",     8'(fim_a), 8'(m_fim[0]));
        chk("b.numero",  8'(num_b), 8'(m_num[1]));
        chk("b.insere",  8'(ins_b), 8'(m_ins[1]));
        chk("b.ocupado", 8'(ocu_b), 8'(m_act[1]));
        chk("b.indice",  8'(idx_b), 8'(m_idx[1]));
        chk("b.fim",     8'(fim_b), 8'(m_fim[1]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic ini, input logic ab);
        iniciar = ini;
        abortar = ab;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(0);
        model_edge(1);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        model_reset(0);
        model_reset(1);

        // Reset values.
        idle(2);
        #2 rst = 1'b0;
        idle(3);

        // Plain run; a second iniciar pulse during digit 1 must be ignored.
        step(1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0);
        idle(30);

        // Asynchronous reset between edges during digit 3 of the GAP=3 run.
        step(1'b1, 1'b0);
        idle(13);
        #2 rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        step(1'b1, 1'b0);
        #2 rst = 1'b0;
        idle(3);
        step(1'b1, 1'b0);
        idle(30);

        // Abort during the gap after digit 2.
        step(1'b1, 1'b0);
        idle(9);
        step(1'b0, 1'b1);
        idle(10);

        // abortar and iniciar together in OCIOSO: stay idle.
        step(1'b1, 1'b1);
        idle(3);

        // iniciar held high: back-to-back runs.
        for (int k = 0; k < 60; k++) step(1'b1, 1'b0);
        idle(30);

        // Digit corruption on index 2, then an out-of-range index.
        erro_en = 1'b1;
        erro_idx = 3'd2;
        step(1'b1, 1'b0);
        erro_en = 1'b0;
        erro_idx = 3'd0;
        idle(30);
        erro_en = 1'b1;
        erro_idx = 3'd7;
        step(1'b1, 1'b0);
        idle(30);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            erro_en = 1'($urandom_range(0, 1));
            erro_idx = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
        end
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
